packet_framer_tx: RTL and testbench

- Drains the read side of the team's packet buffer: pop, nempty, data, length, start and end flags.
- Emits each committed packet as a framed byte stream on a valid/ready link toward the serializer: SYNC, LENGTH, payload, CHECK.
- Enforces a minimum inter-frame gap.
- Detects and reports misaligned or malformed packets so the far-end deframer can resynchronise.

---
 rtl/packet_framer_tx.sv | 179 +++++++++++++++++
 tb/tb_packet_framer_tx.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_framer_tx.sv
// Packet framer: drains the packet buffer read port and emits SYNC, LENGTH,
// payload, CHECK frames on a valid/ready link with a minimum inter-frame gap.
module packet_framer_tx #(
    parameter int unsigned          DATA_BITS   = 8,
    parameter int unsigned          LENGTH_BITS = 8,
    parameter logic [DATA_BITS-1:0] SYNC_WORD   = DATA_BITS'(8'hA5),
    parameter int unsigned          GAP_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   buf_pop,
    input  logic                   buf_nempty,
    input  logic [DATA_BITS-1:0]   buf_data,
    input  logic [LENGTH_BITS-1:0] buf_length,
    input  logic                   buf_start,
    input  logic                   buf_end,
    output logic [DATA_BITS-1:0]   tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [15:0]            frames_sent,
    output logic                   err_align,
    output logic                   err_length
);

    localparam int unsigned CNT_BITS = LENGTH_BITS + 1;
    localparam int unsigned GAP_BITS = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    logic [2:0]             r_state,      w_state;
    logic [GAP_BITS-1:0]    r_gap_cnt,    w_gap_cnt;
    logic [DATA_BITS-1:0]   r_tx_data,    w_tx_data;
    logic                   r_tx_valid,   w_tx_valid;
    logic [15:0]            r_frames,     w_frames;
    logic                   r_err_align,  w_err_align;
    logic                   r_err_length, w_err_length;
    logic                   r_busy,       w_busy;
    logic [DATA_BITS-1:0]   r_csum,       w_csum;
    logic [LENGTH_BITS-1:0] r_len,        w_len;
    logic [CNT_BITS-1:0]    r_count,      w_count;
    logic                   r_mismatch,   w_mismatch;
    logic                   w_pop;
    logic                   w_free;
    logic                   w_gap_done;
    logic [CNT_BITS-1:0]    w_count_inc;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_gap_cnt    <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_frames     <= '0;
            r_err_align  <= 1'b0;
            r_err_length <= 1'b0;
            r_busy       <= 1'b0;
            r_csum       <= '0;
            r_len        <= '0;
            r_count      <= '0;
            r_mismatch   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_gap_cnt    <= w_gap_cnt;
            r_tx_data    <= w_tx_data;
            r_tx_valid   <= w_tx_valid;
            r_frames     <= w_frames;
            r_err_align  <= w_err_align;
            r_err_length <= w_err_length;
            r_busy       <= w_busy;
            r_csum       <= w_csum;
            r_len        <= w_len;
            r_count      <= w_count;
            r_mismatch   <= w_mismatch;
        end
    end

    // Next-state, output-register load and buffer pop decisions
    always_comb begin
        w_state      = r_state;
        w_gap_cnt    = r_gap_cnt;
        w_tx_data    = r_tx_data;
        w_tx_valid   = r_tx_valid && !tx_ready;
        w_frames     = r_frames;
        w_err_align  = 1'b0;
        w_err_length = 1'b0;
        w_csum       = r_csum;
        w_len        = r_len;
        w_count      = r_count;
        w_mismatch   = r_mismatch;
        w_pop        = 1'b0;
        w_free       = !r_tx_valid || tx_ready;
        w_count_inc  = r_count + CNT_BITS'(1);
        // Counter reaches zero this cycle, so SYNC goes valid GAP_CYCLES idle cycles after CHECK
        w_gap_done   = (r_gap_cnt <= GAP_BITS'(1));

        case (r_state)
            S_IDLE: begin
                if (r_gap_cnt != '0) begin
                    w_gap_cnt = r_gap_cnt - GAP_BITS'(1);
                end
                if (w_gap_done && buf_nempty) begin
                    if (!buf_start) begin
                        w_pop       = 1'b1;
                        w_err_align = 1'b1;
                    end else if (w_free) begin
                        w_tx_data  = SYNC_WORD;
                        w_tx_valid = 1'b1;
                        w_len      = buf_length;
                        w_count    = '0;
                        w_mismatch = 1'b0;
                        w_state    = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (w_free) begin
                    w_tx_data  = DATA_BITS'(r_len);
                    w_tx_valid = 1'b1;
                    w_csum     = DATA_BITS'(r_len);
                    w_state    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_free && buf_nempty) begin
                    // A start flag past the first word means the packet was truncated; leave it for the next frame
                    if (buf_start && (r_count != '0)) begin
                        w_mismatch = 1'b1;
                        w_state    = S_CHECK;
                    end else begin
                        w_pop      = 1'b1;
                        w_tx_data  = buf_data;
                        w_tx_valid = 1'b1;
                        w_csum     = r_csum ^ buf_data;
                        w_count    = w_count_inc;
                        if (buf_end) begin
                            w_mismatch = (w_count_inc != CNT_BITS'(r_len));
                            w_state    = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (w_free) begin
                    w_tx_data    = r_mismatch ? ~r_csum : r_csum;
                    w_tx_valid   = 1'b1;
                    w_err_length = r_mismatch;
                    w_state      = S_GAP;
                end
            end
            S_GAP: begin
                if (r_tx_valid && tx_ready) begin
                    w_frames  = r_frames + 16'd1;
                    w_gap_cnt = GAP_BITS'(GAP_CYCLES);
                    w_state   = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign buf_pop     = w_pop && !rst;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign busy        = r_busy;
    assign frames_sent = r_frames;
    assign err_align   = r_err_align;
    assign err_length  = r_err_length;

endmodule

// File: tb/tb_packet_framer_tx.sv
// Bench for packet_framer_tx: a queue-backed buffer model feeds the DUT and a
// frame-level reference model predicts the byte stream, counters and pulses.
module tb_packet_framer_tx;

    localparam int unsigned GAP  = 2;
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef struct {
        logic [7:0] d;
        logic [7:0] l;
        bit         s;
        bit         e;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        buf_pop;
    logic        buf_nempty;
    logic [7:0]  buf_data;
    logic [7:0]  buf_length;
    logic        buf_start;
    logic        buf_end;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] frames_sent;
    logic        err_align;
    logic        err_length;

    packet_framer_tx #(
        .DATA_BITS  (8),
        .LENGTH_BITS(8),
        .SYNC_WORD  (SYNC),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .buf_pop    (buf_pop),
        .buf_nempty (buf_nempty),
        .buf_data   (buf_data),
        .buf_length (buf_length),
        .buf_start  (buf_start),
        .buf_end    (buf_end),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frames_sent(frames_sent),
        .err_align  (err_align),
        .err_length (err_length)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ent_t       q[$];
    ent_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         mode    = 0;
    bit         mask_en = 0;
    logic [7:0] obs_b[$];
    int         obs_v[$];
    int         obs_h[$];
    int         n_pop = 0;
    int         n_align = 0;
    int         n_lenerr = 0;
    bit         prev_valid = 0;
    bit         prev_ready = 0;
    bit         prev_hs = 0;
    logic [7:0] prev_data = 8'h00;
    int         cur_vstart = 0;
    logic [7:0] exp_b[$];
    int         exp_fs[$];
    int         exp_fe[$];
    int         exp_align;
    int         exp_lenerr;
    int         exp_nf;
    int         exp_frames_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] l, input bit s, input bit e);
        ent_t x;
        x.d = d; x.l = l; x.s = s; x.e = e;
        q.push_back(x);
        sb.push_back(x);
    endtask

    task automatic push_pkt(input logic [7:0] b[$], input logic [7:0] lenf, input bit term);
        for (int k = 0; k < b.size(); k++)
            push(b[k], lenf, k == 0, term && (k == b.size() - 1));
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later
    task automatic cycle();
        case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ((cyc % 3) == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        if (q.size() > 0 && !(mask_en && $urandom_range(0, 3) == 0)) begin
            buf_nempty = 1'b1;
            buf_data   = q[0].d;
            buf_length = q[0].l;
            buf_start  = q[0].s;
            buf_end    = q[0].e;
        end else begin
            buf_nempty = 1'b0;
            buf_data   = 8'($urandom);
            buf_length = 8'($urandom);
            buf_start  = 1'($urandom);
            buf_end    = 1'($urandom);
        end
        #1;
        if (prev_valid && !prev_ready) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (buf_pop) begin
            check("pop_needs_nempty", 32'(buf_nempty), 32'd1);
            check("pop_while_occupied", 32'(tx_valid && !tx_ready), 32'd0);
            n_pop++;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (tx_valid && (!prev_valid || prev_hs)) cur_vstart = cyc;
        if (tx_valid && tx_ready) begin
            obs_b.push_back(tx_data);
            obs_v.push_back(cur_vstart);
            obs_h.push_back(cyc);
        end
        if (err_align)  n_align++;
        if (err_length) n_lenerr++;
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_hs    = tx_valid && tx_ready;
        prev_data  = tx_data;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_done(input int limit);
        int k;
        k = 0;
        while (k < limit && !(q.size() == 0 && !busy && !tx_valid)) begin
            cycle();
            k++;
        end
        check("drain_timeout", 32'(k < limit), 32'd1);
        repeat (GAP + 2) cycle();
    endtask

    // Frame-level reference: walk buffer entries and apply the framing rules
    function automatic void build_expected();
        int         i;
        int         cnt;
        logic [7:0] cs;
        logic [7:0] lenf;
        bit         mism;
        exp_b.delete(); exp_fs.delete(); exp_fe.delete();
        exp_align = 0; exp_lenerr = 0; exp_nf = 0;
        i = 0;
        while (i < sb.size()) begin
            if (!sb[i].s) begin
                exp_align++;
                i++;
            end else begin
                lenf = sb[i].l;
                exp_fs.push_back(exp_b.size());
                exp_b.push_back(SYNC);
                exp_b.push_back(lenf);
                cs = lenf; cnt = 0; mism = 0;
                while (i < sb.size()) begin
                    if (cnt > 0 && sb[i].s) begin
                        mism = 1;
                        break;
                    end
                    exp_b.push_back(sb[i].d);
                    cs = cs ^ sb[i].d;
                    cnt++;
                    i++;
                    if (sb[i-1].e) begin
                        mism = (cnt != int'(lenf));
                        break;
                    end
                end
                exp_b.push_back(mism ? ~cs : cs);
                exp_fe.push_back(exp_b.size() - 1);
                if (mism) exp_lenerr++;
                exp_nf++;
            end
        end
    endfunction

    task automatic check_scn(input string tag, input bit exact);
        int idle;
        build_expected();
        exp_frames_total += exp_nf;
        check({tag, "_nbytes"}, 32'(obs_b.size()), 32'(exp_b.size()));
        for (int k = 0; k < exp_b.size(); k++)
            if (k < obs_b.size())
                check($sformatf("%s_byte%0d", tag, k), 32'(obs_b[k]), 32'(exp_b[k]));
        check({tag, "_frames_sent"}, 32'(frames_sent), 32'(exp_frames_total[15:0]));
        check({tag, "_err_align"}, 32'(n_align), 32'(exp_align));
        check({tag, "_err_length"}, 32'(n_lenerr), 32'(exp_lenerr));
        check({tag, "_pops"}, 32'(n_pop), 32'(sb.size()));
        for (int f = 1; f < exp_fs.size(); f++) begin
            if (exp_fs[f] < obs_b.size()) begin
                idle = obs_v[exp_fs[f]] - obs_h[exp_fe[f-1]] - 1;
                if (exact) check($sformatf("%s_gap%0d", tag, f), 32'(idle), 32'(GAP));
                else       check($sformatf("%s_gapmin%0d", tag, f), 32'(idle >= GAP), 32'd1);
            end
        end
        if (exact) begin
            for (int f = 0; f < exp_fs.size(); f++)
                for (int k = exp_fs[f] + 1; k <= exp_fe[f]; k++)
                    if (k < obs_h.size())
                        check($sformatf("%s_consec%0d", tag, k), 32'(obs_h[k] - obs_h[k-1]), 32'd1);
        end
        obs_b.delete(); obs_v.delete(); obs_h.delete(); sb.delete();
        n_pop = 0; n_align = 0; n_lenerr = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pk[$];
        int         c0;
        int         k;
        int         n;
        int         kind;
        bit         open;

        rst = 1'b1; tx_ready = 1'b0;
        buf_nempty = 1'b0; buf_data = 8'h00; buf_length = 8'h00; buf_start = 1'b0; buf_end = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_align", 32'(err_align), 32'd0);
        check("rst_err_length", 32'(err_length), 32'd0);
        buf_nempty = 1'b1; buf_start = 1'b0;
        #1;
        check("rst_pop_forced", 32'(buf_pop), 32'd0);
        buf_nempty = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) cycle();

        // Basic frame, continuous ready
        mode = 0;
        pk = '{8'h11, 8'h22, 8'h33};
        push_pkt(pk, 8'd3, 1);
        c0 = cyc;
        cycle();
        check("s1_busy", 32'(busy), 32'd1);
        run_done(200);
        if (obs_v.size() > 0) check("s1_latency", 32'(obs_v[0]), 32'(c0 + 1));
        else                  check("s1_latency_none", 32'(obs_v.size()), 32'd1);
        check_scn("s1", 1);

        // Same frame with ready pattern 1,0,0
        mode = 1;
        push_pkt(pk, 8'd3, 1);
        run_done(300);
        check_scn("s2", 0);

        // Two queued packets: exact gap between frames
        mode = 0;
        pk = '{8'h7E};
        push_pkt(pk, 8'd1, 1);
        pk = '{8'h01, 8'h02};
        push_pkt(pk, 8'd2, 1);
        run_done(200);
        check_scn("s3", 1);

        // Stray non-start entry ahead of a packet
        push(8'h55, 8'h00, 0, 0);
        pk = '{8'h10, 8'h20};
        push_pkt(pk, 8'd2, 1);
        run_done(200);
        check_scn("s4", 1);

        // Length field disagrees with end flag
        pk = '{8'hAA, 8'hBB, 8'hCC};
        push_pkt(pk, 8'd4, 1);
        run_done(200);
        check_scn("s5", 1);

        // Truncated packet followed by the next start
        pk = '{8'h31, 8'h32};
        push_pkt(pk, 8'd3, 0);
        pk = '{8'h41};
        push_pkt(pk, 8'd1, 1);
        run_done(200);
        check_scn("s5t", 0);

        // Reset in the middle of the payload
        pk = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        push_pkt(pk, 8'd6, 1);
        k = 0;
        while (k < 50 && n_pop < 2) begin
            cycle();
            k++;
        end
        check("s6_reach_payload", 32'(k < 50), 32'd1);
        check("s6_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("s6_rst_valid", 32'(tx_valid), 32'd0);
        check("s6_rst_pop", 32'(buf_pop), 32'd0);
        @(negedge clk);
        check("s6_rst_frames", 32'(frames_sent), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        exp_frames_total = 0;
        obs_b.delete(); obs_v.delete(); obs_h.delete();
        n_pop = 0; n_align = 0; n_lenerr = 0;
        prev_valid = 0; prev_ready = 0; prev_hs = 0;
        sb = q;
        rst = 1'b0;
        pk = '{8'h61, 8'h62};
        push_pkt(pk, 8'd2, 1);
        run_done(300);
        check_scn("s6", 0);

        // Randomized packets, ready and buffer availability
        mode = 2;
        mask_en = 1;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(3, 6);
            open = 0;
            for (int p = 0; p < n; p++) begin
                kind = $urandom_range(0, 9);
                if (kind == 0 && !open) push(8'($urandom), 8'($urandom), 0, 1'($urandom));
                pk.delete();
                for (int b = 0; b < $urandom_range(1, 5); b++) pk.push_back(8'($urandom));
                open = (kind == 2) && (p != n - 1);
                push_pkt(pk, (kind == 1) ? 8'($urandom_range(0, 7)) : 8'(pk.size()), !open);
            end
            run_done(3000);
            check_scn($sformatf("rnd%0d", it), 0);
        end
        mask_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
